// File: rtl/xor_cipher_pkg.sv
// Shared definitions for the serial XOR stream cipher.
// Contents:
//   state_t  - cipher FSM states
//   DEF_*    - default geometry (key/message length, clock divide ratio)
//   cnt_w()  - width of a counter that must hold the values 0..n inclusive
package xor_cipher_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_KEY,
        LOAD_MSG,
        OUTPUT,
        DONE
    } state_t;

    localparam int DEF_KEY_W   = 8;
    localparam int DEF_MSG_W   = 8;
    localparam int DEF_CLK_DIV = 4;

    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/xor_clk_div.sv
// Free-running clock divider for the cipher's slow bit clock.
// Ports:
//   clk      in   system clock
//   rst      in   synchronous active-high reset
//   clk_slow out  divided clock, 50% duty, period CLK_DIV clk cycles
//   tick     out  one-cycle strobe in the last clk cycle of each slow period
// The divider ignores any enable so the exported clock never stalls.
module xor_clk_div #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    output logic clk_slow,
    output logic tick
);
    localparam int DIV_W = $clog2(CLK_DIV);

    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] div_cnt_nxt;

    assign tick        = (div_cnt == DIV_W'(CLK_DIV - 1));
    assign div_cnt_nxt = tick ? '0 : div_cnt + DIV_W'(1);

    // clk_slow is registered from the next count so the exported pin is
    // glitch-free; it still tracks (div_cnt >= CLK_DIV/2) cycle for cycle,
    // which puts its falling edge on the same clk edge that tick acts on.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt  <= '0;
            clk_slow <= 1'b0;
        end else begin
            div_cnt  <= div_cnt_nxt;
            clk_slow <= (div_cnt_nxt >= DIV_W'(CLK_DIV / 2));
        end
    end

endmodule

// File: rtl/franco_xor_top.sv
// Serial XOR stream cipher with integrated clock divider.
// A key and then a message are shifted in MSB first, one bit per slow tick;
// the message is then shifted out XOR-ed with the (cyclically reused) key.
// Ports:
//   iClk        in   system clock, all flops on posedge
//   iRst        in   synchronous active-high reset
//   iEn         in   enable; 0 freezes FSM, shift registers and counters
//   iData_in    in   serial key/message bit, sampled on tick
//   iLoad_key   in   level: shift iData_in into key (priority over iLoad_msg)
//   iLoad_msg   in   level: shift iData_in into message (needs full key)
//   oClk_slow   out  divided bit clock for the external device
//   oData_out   out  registered serial ciphertext bit
//   oDone_flag  out  high once all MSG_W cipher bits have been emitted
module franco_xor_top
    import xor_cipher_pkg::*;
#(
    parameter int KEY_W   = DEF_KEY_W,
    parameter int MSG_W   = DEF_MSG_W,
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input  logic iClk,
    input  logic iRst,
    input  logic iEn,
    input  logic iData_in,
    input  logic iLoad_key,
    input  logic iLoad_msg,
    output logic oClk_slow,
    output logic oData_out,
    output logic oDone_flag
);
    localparam int KC_W = cnt_w(KEY_W);
    localparam int MC_W = cnt_w(MSG_W);

    logic tick;

    xor_clk_div #(.CLK_DIV(CLK_DIV)) u_div (
        .clk      (iClk),
        .rst      (iRst),
        .clk_slow (oClk_slow),
        .tick     (tick)
    );

    state_t           state,    state_nxt;
    logic [KEY_W-1:0] key,      key_nxt;
    logic [KEY_W-1:0] key_rot,  key_rot_nxt;
    logic [MSG_W-1:0] msg,      msg_nxt;
    logic [KC_W-1:0]  key_cnt,  key_cnt_nxt;
    logic [MC_W-1:0]  msg_cnt,  msg_cnt_nxt;
    logic [MC_W-1:0]  out_idx,  out_idx_nxt;
    logic             data_out, data_out_nxt;
    logic             done,     done_nxt;

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state    <= IDLE;
            key      <= '0;
            key_rot  <= '0;
            msg      <= '0;
            key_cnt  <= '0;
            msg_cnt  <= '0;
            out_idx  <= '0;
            data_out <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_nxt;
            key      <= key_nxt;
            key_rot  <= key_rot_nxt;
            msg      <= msg_nxt;
            key_cnt  <= key_cnt_nxt;
            msg_cnt  <= msg_cnt_nxt;
            out_idx  <= out_idx_nxt;
            data_out <= data_out_nxt;
            done     <= done_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        key_nxt      = key;
        key_rot_nxt  = key_rot;
        msg_nxt      = msg;
        key_cnt_nxt  = key_cnt;
        msg_cnt_nxt  = msg_cnt;
        out_idx_nxt  = out_idx;
        data_out_nxt = data_out;
        done_nxt     = done;

        if (tick && iEn) begin
            if (state == OUTPUT) begin
                // out_idx == MSG_W means the last bit has already been held
                // for a full slow period.
                if (out_idx == MC_W'(MSG_W)) begin
                    data_out_nxt = 1'b0;
                    done_nxt     = 1'b1;
                    state_nxt    = DONE;
                end else begin
                    // msg is consumed MSB first; key_rot is a rotating copy
                    // so the key itself survives for the next message and
                    // wraps cyclically when MSG_W > KEY_W.
                    data_out_nxt = msg[MSG_W-1] ^ key_rot[KEY_W-1];
                    msg_nxt      = msg << 1;
                    key_rot_nxt  = (key_rot << 1) | (key_rot >> (KEY_W - 1));
                    out_idx_nxt  = out_idx + MC_W'(1);
                end
            end else if (iLoad_key) begin
                key_nxt     = (key << 1) | KEY_W'(iData_in);
                key_cnt_nxt = (key_cnt == KC_W'(KEY_W)) ? key_cnt : key_cnt + KC_W'(1);
                msg_cnt_nxt = '0;
                done_nxt    = 1'b0;
                state_nxt   = LOAD_KEY;
            end else if (iLoad_msg && key_cnt == KC_W'(KEY_W)) begin
                msg_nxt  = (msg << 1) | MSG_W'(iData_in);
                done_nxt = 1'b0;
                if (msg_cnt == MC_W'(MSG_W - 1)) begin
                    msg_cnt_nxt = '0;
                    out_idx_nxt = '0;
                    key_rot_nxt = key;
                    state_nxt   = OUTPUT;
                end else begin
                    msg_cnt_nxt = msg_cnt + MC_W'(1);
                    state_nxt   = LOAD_MSG;
                end
            end
        end
    end

    assign oData_out  = data_out;
    assign oDone_flag = done;

endmodule

// File: tb/tb_franco_xor_top.sv
// Self-checking bench for franco_xor_top (KEY_W=MSG_W=8, CLK_DIV=4).
// Inputs change just after the slow clock falls and are held for one full
// slow period; every iClk negedge compares the outputs to a bit-level model.
module tb_franco_xor_top;
    localparam int KW = 8;
    localparam int MW = 8;
    localparam int CD = 4;

    logic iClk = 1'b0;
    logic iRst, iEn, iData_in, iLoad_key, iLoad_msg;
    logic oClk_slow, oData_out, oDone_flag;

    franco_xor_top #(.KEY_W(KW), .MSG_W(MW), .CLK_DIV(CD)) dut (
        .iClk       (iClk),
        .iRst       (iRst),
        .iEn        (iEn),
        .iData_in   (iData_in),
        .iLoad_key  (iLoad_key),
        .iLoad_msg  (iLoad_msg),
        .oClk_slow  (oClk_slow),
        .oData_out  (oData_out),
        .oDone_flag (oDone_flag)
    );

    always #5 iClk = ~iClk;

    int n_chk  = 0;
    int n_fail = 0;

    // Behavioural model: key/message as plain values, the ciphertext as a
    // queue of bits computed all at once when the message completes.
    logic [KW-1:0] m_key;
    logic [MW-1:0] m_msg;
    int            m_kn, m_mn;
    bit            m_busy, m_out, m_done;
    bit            m_q[$];

    logic [7:0] cap;

    typedef struct {
        bit d, lk, lm, en;
        bit exp_out, exp_done;
    } vec_t;
    vec_t tbl[$];

    task automatic check(input string name, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_key = '0; m_msg = '0; m_kn = 0; m_mn = 0;
        m_busy = 0; m_out = 0; m_done = 0;
        m_q.delete();
    endtask

    task automatic model_tick(input bit d, input bit lk, input bit lm, input bit en);
        if (!en) return;
        if (m_busy) begin
            if (m_q.size() > 0) m_out = m_q.pop_front();
            else begin m_out = 0; m_done = 1; m_busy = 0; end
        end else if (lk) begin
            m_key = {m_key[KW-2:0], d};
            if (m_kn < KW) m_kn++;
            m_mn = 0; m_done = 0;
        end else if (lm && m_kn == KW) begin
            m_msg = {m_msg[MW-2:0], d};
            m_mn++; m_done = 0;
            if (m_mn == MW) begin
                for (int i = 0; i < MW; i++)
                    m_q.push_back(m_msg[MW-1-i] ^ m_key[KW-1-(i % KW)]);
                m_busy = 1; m_mn = 0;
            end
        end
    endtask

    // One slow period: starts and ends at the iClk negedge following a tick.
    task automatic step(input bit d, input bit lk, input bit lm, input bit en);
        iData_in = d; iLoad_key = lk; iLoad_msg = lm; iEn = en;
        for (int c = 0; c < CD; c++) begin
            @(posedge iClk);
            if (c == CD - 1) model_tick(d, lk, lm, en);
            @(negedge iClk);
            check("clk_slow", oClk_slow, ((c + 1) % CD) >= CD / 2);
            check("data_out", oData_out, m_out);
            check("done",     oDone_flag, m_done);
        end
    endtask

    task automatic do_reset();
        iRst = 1; iEn = 1; iData_in = 0; iLoad_key = 0; iLoad_msg = 0;
        repeat (3) @(posedge iClk);
        @(negedge iClk);
        check("rst_data",  oData_out, 1'b0);
        check("rst_done",  oDone_flag, 1'b0);
        check("rst_clk",   oClk_slow, 1'b0);
        model_reset();
        iRst = 0;
    endtask

    task automatic load_key(input logic [7:0] k, input int nbits);
        for (int i = 7; i > 7 - nbits; i--) step(k[i], 1, 0, 1);
    endtask

    task automatic load_msg(input logic [7:0] m);
        for (int i = 7; i >= 0; i--) step(m[i], 0, 1, 1);
    endtask

    task automatic run_out(input int n);
        for (int i = 0; i < n; i++) begin
            step(0, 0, 0, 1);
            cap = {cap[6:0], oData_out};
        end
    endtask

    function automatic void add(input bit d, lk, lm, en, eo, ed);
        vec_t v;
        v.d = d; v.lk = lk; v.lm = lm; v.en = en; v.exp_out = eo; v.exp_done = ed;
        tbl.push_back(v);
    endfunction

    initial begin
        logic [7:0] k_v, m_v, c_v;
        k_v = 8'hA5; m_v = 8'h3C; c_v = 8'h99;
        for (int i = 7; i >= 0; i--) add(k_v[i], 1, 0, 1, 0, 0);
        for (int i = 7; i >= 0; i--) add(m_v[i], 0, 1, 1, 0, 0);
        for (int i = 7; i >= 0; i--) add(0, 0, 0, 1, c_v[i], 0);
        add(0, 0, 0, 1, 0, 1);

        do_reset();
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);

        // Key A5, message 3C -> 99, then done one slow period later.
        foreach (tbl[i]) begin
            step(tbl[i].d, tbl[i].lk, tbl[i].lm, tbl[i].en);
            check("tbl_out",  oData_out, tbl[i].exp_out);
            check("tbl_done", oDone_flag, tbl[i].exp_done);
        end

        // Reuse the key: FF -> 5A; done clears on the first message bit.
        step(1, 0, 1, 1);
        check("done_clr", oDone_flag, 1'b0);
        for (int i = 6; i >= 0; i--) step(1, 0, 1, 1);
        cap = '0;
        run_out(8);
        check8("reload_ct", cap, 8'h5A);
        step(0, 0, 0, 1);
        check("reload_done", oDone_flag, 1'b1);

        // Pause 12 iClk in the middle of OUTPUT.
        load_msg(8'h3C);
        cap = '0;
        run_out(3);
        for (int i = 0; i < 3; i++) step(0, 1, 1, 0);
        run_out(5);
        check8("pause_ct", cap, 8'h99);
        step(0, 0, 0, 1);
        check("pause_done", oDone_flag, 1'b1);

        // Reset mid-output: key lost, message load refused.
        load_msg(8'h3C);
        run_out(3);
        do_reset();
        load_msg(8'h3C);
        for (int i = 0; i < 10; i++) step(0, 0, 0, 1);
        check("norekey_done", oDone_flag, 1'b0);

        // Partial key (4 bits) then message: ignored.
        load_key(8'hA5, 4);
        load_msg(8'hC3);
        for (int i = 0; i < 10; i++) step(0, 0, 0, 1);
        check("partkey_done", oDone_flag, 1'b0);

        // Randomized traffic against the model.
        load_key(8'h5C, 8);
        for (int i = 0; i < 400; i++) begin
            bit d, lk, lm, en;
            d  = bit'($urandom_range(0, 1));
            lk = ($urandom_range(0, 99) < 8);
            lm = ($urandom_range(0, 99) < 55);
            en = ($urandom_range(0, 99) < 85);
            step(d, lk, lm, en);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
